// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 integer register file and its read ports.
package msrv32_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;
endpackage

// File: rtl/msrv32_rf_read_port.sv
// One combinational register-file read port: x0 zeroing, reset gating,
// write-back bypass and array mux.
module msrv32_rf_read_port
  import msrv32_pkg::*;
#(
  parameter int P_XLEN  = XLEN,
  parameter int P_NREGS = NREGS
) (
  input  logic                      rst,
  input  logic [REG_ADDR_W-1:0]     addr,
  input  logic                      wr_en,
  input  logic [REG_ADDR_W-1:0]     wr_addr,
  input  logic [P_XLEN-1:0]         wr_data,
  input  logic [P_NREGS*P_XLEN-1:0] regs_flat,
  output logic [P_XLEN-1:0]         data
);

  // Priority: reset and x0 force zero, then the in-flight write wins over storage.
  always_comb begin
    data = '0;
    if (rst || addr == X0_ADDR || int'(addr) >= P_NREGS) begin
      data = '0;
    end else if (wr_en && wr_addr == addr) begin
      data = wr_data;
    end else begin
      data = regs_flat[int'(addr)*P_XLEN +: P_XLEN];
    end
  end

endmodule

// File: rtl/msrv32_integer_file.sv
// RV32 integer register file: x1..x(NREGS-1) storage, two bypassed read ports,
// and a 16-bit count of committed writes since reset.
module msrv32_integer_file
  import msrv32_pkg::*;
#(
  parameter int XLEN  = msrv32_pkg::XLEN,
  parameter int NREGS = msrv32_pkg::NREGS
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  wr_en_in,
  input  logic [XLEN-1:0]       rd_in,
  output logic [XLEN-1:0]       rs_1_out,
  output logic [XLEN-1:0]       rs_2_out,
  output logic [15:0]           rf_wr_count_out
);

  logic [XLEN-1:0]       regs [1:NREGS-1];
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [15:0]           wr_count;
  logic                  wr_commit;

  // Writes to x0 or past the last register are dropped and not counted.
  assign wr_commit = wr_en_in && (rd_addr_in != X0_ADDR) && (int'(rd_addr_in) < NREGS);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_commit) begin
      regs[rd_addr_in] <= rd_in;
      wr_count         <= wr_count + 16'd1;
    end
  end

  // Slot 0 is a constant zero so the flat view lines up with register indices.
  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_flat[i*XLEN +: XLEN] = regs[i];
    end
  end

  assign rf_wr_count_out = wr_count;

  msrv32_rf_read_port #(.P_XLEN(XLEN), .P_NREGS(NREGS)) u_read_port_1 (
    .rst       (ms_riscv32_mp_rst_in),
    .addr      (rs_1_addr_in),
    .wr_en     (wr_en_in),
    .wr_addr   (rd_addr_in),
    .wr_data   (rd_in),
    .regs_flat (regs_flat),
    .data      (rs_1_out)
  );

  msrv32_rf_read_port #(.P_XLEN(XLEN), .P_NREGS(NREGS)) u_read_port_2 (
    .rst       (ms_riscv32_mp_rst_in),
    .addr      (rs_2_addr_in),
    .wr_en     (wr_en_in),
    .wr_addr   (rd_addr_in),
    .wr_data   (rd_in),
    .regs_flat (regs_flat),
    .data      (rs_2_out)
  );

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed bench for msrv32_integer_file: reset, write/read, bypass, x0,
// reset priority, back-to-back writes and write-counter wrap.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_1_addr;
  logic [4:0]  rs_2_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] rs_1_data;
  logic [31:0] rs_2_data;
  logic [15:0] wr_count;

  int n_vec;
  int n_err;

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .rs_1_addr_in         (rs_1_addr),
    .rs_2_addr_in         (rs_2_addr),
    .rd_addr_in           (rd_addr),
    .wr_en_in             (wr_en),
    .rd_in                (rd_data),
    .rs_1_out             (rs_1_data),
    .rs_2_out             (rs_2_data),
    .rf_wr_count_out      (wr_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    rd_addr   = 5'd0;
    rd_data   = 32'd0;
    rs_1_addr = 5'd0;
    rs_2_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rs_1_addr = 5'd4;
    rs_2_addr = 5'd9;
    #1;
    n_vec++;
    if (rs_1_data !== 32'd0 || rs_2_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs_zero: rs1=%h rs2=%h expected 0/0", rs_1_data, rs_2_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_1_addr = 5'(i);
      rs_2_addr = 5'(31 - i);
      #1;
      n_vec++;
      if (rs_1_data !== 32'd0 || rs_2_data !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read_x%0d: rs1=%h rs2=%h expected 0", i, rs_1_data, rs_2_data);
      end
    end
    n_vec++;
    if (wr_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", wr_count);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'hAABBCCDD;
    tick();
    wr_en = 1'b0; rs_1_addr = 5'd5; rs_2_addr = 5'd6;
    #1;
    n_vec++;
    if (rs_1_data !== 32'hAABBCCDD) begin
      n_err++;
      $display("FAIL write_read_x5: got %h expected aabbccdd", rs_1_data);
    end
    n_vec++;
    if (rs_2_data !== 32'd0) begin
      n_err++;
      $display("FAIL write_read_x6_untouched: got %h expected 0", rs_2_data);
    end
    n_vec++;
    if (wr_count !== 16'd1) begin
      n_err++;
      $display("FAIL write_read_count: got %0d expected 1", wr_count);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678;
    rs_1_addr = 5'd7; rs_2_addr = 5'd7;
    #1;
    n_vec++;
    if (rs_2_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_rs2: got %h expected 12345678", rs_2_data);
    end
    n_vec++;
    if (rs_1_data !== rs_2_data || rs_1_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_same_index: rs1=%h rs2=%h expected 12345678", rs_1_data, rs_2_data);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_vec++;
    if (rs_1_data !== 32'h12345678 || rs_2_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_stored: rs1=%h rs2=%h expected 12345678", rs_1_data, rs_2_data);
    end
    n_vec++;
    if (wr_count !== 16'd2) begin
      n_err++;
      $display("FAIL bypass_count: got %0d expected 2", wr_count);
    end
  endtask

  task automatic test_x0_write();
    wr_en = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
    rs_1_addr = 5'd0; rs_2_addr = 5'd5;
    #1;
    n_vec++;
    if (rs_1_data !== 32'd0) begin
      n_err++;
      $display("FAIL x0_before_edge: got %h expected 0", rs_1_data);
    end
    n_vec++;
    if (rs_2_data !== 32'hAABBCCDD) begin
      n_err++;
      $display("FAIL x0_no_bypass_other: got %h expected aabbccdd", rs_2_data);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_vec++;
    if (rs_1_data !== 32'd0) begin
      n_err++;
      $display("FAIL x0_after_edge: got %h expected 0", rs_1_data);
    end
    n_vec++;
    if (wr_count !== 16'd2) begin
      n_err++;
      $display("FAIL x0_count: got %0d expected 2", wr_count);
    end
  endtask

  task automatic test_reset_mid_write();
    wr_en = 1'b1; rd_addr = 5'd3; rd_data = 32'h99999999;
    tick();
    rst = 1'b1; rd_data = 32'h55555555;
    rs_1_addr = 5'd3; rs_2_addr = 5'd3;
    #1;
    n_vec++;
    if (rs_1_data !== 32'd0 || rs_2_data !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: rs1=%h rs2=%h expected 0/0", rs_1_data, rs_2_data);
    end
    tick();
    rst = 1'b0; wr_en = 1'b0;
    #1;
    n_vec++;
    if (rs_1_data !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_x3_cleared: got %h expected 0", rs_1_data);
    end
    n_vec++;
    if (wr_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_count: got %0d expected 0", wr_count);
    end
    wr_en = 1'b1; rd_data = 32'h55555555;
    tick();
    wr_en = 1'b0;
    #1;
    n_vec++;
    if (rs_1_data !== 32'h55555555 || wr_count !== 16'd1) begin
      n_err++;
      $display("FAIL rst_mid_first_write: x3=%h count=%0d expected 55555555/1", rs_1_data, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5A5A5;
    tick();
    rd_data = 32'h5A5A0001;
    tick();
    wr_en = 1'b0; rs_1_addr = 5'd9; rs_2_addr = 5'd31;
    #1;
    n_vec++;
    if (rs_1_data !== 32'h5A5A0001) begin
      n_err++;
      $display("FAIL back_to_back_x9: got %h expected 5a5a0001", rs_1_data);
    end
    n_vec++;
    if (wr_count !== 16'd3) begin
      n_err++;
      $display("FAIL back_to_back_count: got %0d expected 3", wr_count);
    end
  endtask

  task automatic test_count_wrap();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    wr_en = 1'b1; rd_addr = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      rd_data = 32'(i) ^ 32'hC0DE0000;
      tick();
      if (i == 65534) begin
        n_vec++;
        if (wr_count !== 16'hFFFF) begin
          n_err++;
          $display("FAIL wrap_count_max: got %h expected ffff", wr_count);
        end
      end
    end
    wr_en = 1'b0; rs_1_addr = 5'd1; rs_2_addr = 5'd1;
    #1;
    n_vec++;
    if (wr_count !== 16'd0) begin
      n_err++;
      $display("FAIL wrap_count_zero: got %h expected 0", wr_count);
    end
    n_vec++;
    if (rs_1_data !== 32'hC0DEFFFF || rs_2_data !== 32'hC0DEFFFF) begin
      n_err++;
      $display("FAIL wrap_x1_last: rs1=%h rs2=%h expected c0deffff", rs_1_data, rs_2_data);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_x0_write();
    test_reset_mid_write();
    test_back_to_back();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msrv32_integer_file.md
MSRV32_INTEGER_FILE -- requirements
Module: msrv32_integer_file

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning number of architectural registers (x0..x31).
REQ-003 The block SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port ms_riscv32_mp_rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rs_1_addr_in, input, 5 bits: read port 1 register index.
REQ-006 The block SHALL have port rs_2_addr_in, input, 5 bits: read port 2 register index.
REQ-007 The block SHALL have port rd_addr_in, input, 5 bits: write-back destination index, driven from the stage-2 pipeline register.
REQ-008 The block SHALL have port wr_en_in, input, 1 bit: write-back enable.
REQ-009 The block SHALL have port rd_in, input, XLEN bits: write-back data, driven by the write-back mux output.
REQ-010 The block SHALL have port rs_1_out, output, XLEN bits: read data for port 1.
REQ-011 The block SHALL have port rs_2_out, output, XLEN bits: read data for port 2.
REQ-012 The block SHALL have port rf_wr_count_out, output, 16 bits: count of committed register writes since reset.

Function
REQ-013 The block SHALL store NREGS-1 writable XLEN-bit registers x1..x31; x0 SHALL have no storage.
REQ-014 On a rising edge with wr_en_in=1, rst=0 and rd_addr_in!=0, the block SHALL write rd_in into x[rd_addr_in].
REQ-015 A write with rd_addr_in=0 SHALL be discarded, and rf_wr_count_out SHALL NOT increment.
REQ-016 Reads SHALL be combinational from the addresses; a read of index 0 SHALL return 0 regardless of any pending write.
REQ-017 Bypass: when wr_en_in=1, rd_addr_in!=0 and rd_addr_in equals a read address in the same cycle, that port SHALL return rd_in, not the stored value.
REQ-018 When both read ports address the same register, both ports SHALL return identical data, including under bypass.
REQ-019 rf_wr_count_out SHALL increment by 1 on each committed write (REQ-014) and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-020 Write latency SHALL be one edge: data written at edge N SHALL be readable from storage after edge N; it SHALL be visible through bypass before edge N.
REQ-021 Back-to-back writes to the same index SHALL leave the last value written.

Reset
REQ-022 While ms_riscv32_mp_rst_in=1 at a rising edge, x1..x31 SHALL clear to 0 and rf_wr_count_out SHALL clear to 0.
REQ-023 A write presented in a reset cycle SHALL be discarded, and bypass SHALL be suppressed while reset is high.
REQ-024 While ms_riscv32_mp_rst_in=1, rs_1_out and rs_2_out SHALL be 0.
REQ-025 Reset asserted in the middle of a write stream SHALL take priority; the first write after deassertion SHALL commit normally.

Structure
REQ-026 XLEN, REG_ADDR_W=5, NREGS and the constant X0_ADDR=5'd0 SHALL be defined in the shared package msrv32_pkg.
REQ-027 The read-port logic (index-0 zeroing, bypass compare, array mux) SHALL be a sub-module msrv32_rf_read_port, instantiated twice.

Verification
REQ-028 Scenario: reset, then read all 32 indices -> every read returns 32'h00000000 and rf_wr_count_out=0.
REQ-029 Scenario: write x5=32'hAABBCCDD, then read rs_1_addr_in=5 on the next cycle -> rs_1_out=32'hAABBCCDD and rf_wr_count_out=1.
REQ-030 Scenario: wr_en_in=1, rd_addr_in=7, rd_in=32'h12345678 with rs_2_addr_in=7 in the same cycle -> rs_2_out=32'h12345678 before the edge.
REQ-031 Scenario: write x0=32'hFFFFFFFF with rs_1_addr_in=0 -> rs_1_out=0 in that cycle and after the edge, and rf_wr_count_out is unchanged.
REQ-032 Scenario: write x3=32'h99999999, then assert reset in the same cycle as a write x3=32'h55555555 -> after the edge x3=0, rf_wr_count_out=0, and both outputs are 0 during reset.
REQ-033 Scenario: 65536 committed writes to x1 -> rf_wr_count_out wraps to 0, and x1 holds the last value written.
